alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Issue stage that sits directly upstream of the 8-bit combinational ALU (add / mul / xor / shift-left-by-1, carry and zero flags).
- Holds a small operand register file and accepts commands over a valid/ready handshake.
- Drives registered A/B/ALU_Sel into the ALU, then captures the ALU result and flags back into the register file.
- Presents each result on a one-cycle result strobe.

Parameters:
- DATA_W, 8, operand/result width; must match the ALU width.
- NREG, 4, number of operand registers.
- REG_AW, 2, register address width, equal to log2(NREG).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command this cycle.
- cmd_load  in  1  1 = load immediate into rd; 0 = ALU operation.
- cmd_op  in  2  ALU select: 00 add, 01 mul, 10 xor, 11 shl.
- cmd_ra  in  REG_AW  source register A.
- cmd_rb  in  REG_AW  source register B.
- cmd_rd  in  REG_AW  destination register.
- cmd_imm  in  DATA_W  immediate value for load.
- alu_a  out  DATA_W  to ALU input A (registered).
- alu_b  out  DATA_W  to ALU input B (registered).
- alu_sel  out  2  to ALU select (registered).
- alu_out  in  DATA_W  from ALU result.
- alu_carry  in  1  from ALU carry-out (always the carry of A+B).
- alu_zf  in  1  from ALU zero flag.
- res_valid  out  1  one-cycle result strobe.
- res_data  out  DATA_W  captured result.
- res_rd  out  REG_AW  destination register of the result.
- res_carry  out  1  carry flag of the result.
- res_zero  out  1  zero flag of the result.
- dbg_addr  in  REG_AW  debug read address.
- dbg_data  out  DATA_W  combinational read of reg[dbg_addr].

Behaviour:
- Reset (rst_n low at a rising edge):
  - All registers, alu_a, alu_b, alu_sel, res_data, res_rd, res_carry, res_zero and res_valid go to 0; state goes to IDLE.
  - cmd_ready is forced to 0 combinationally while rst_n is low.
- State machine, two states:
  - IDLE: cmd_ready = 1. On accept (cmd_valid & cmd_ready):
    - cmd_load = 1: reg[cmd_rd] <= cmd_imm; stay in IDLE; no result strobe.
    - cmd_load = 0: alu_a <= reg[cmd_ra], alu_b <= reg[cmd_rb], alu_sel <= cmd_op; latch rd and op; go to EXEC.
  - EXEC: cmd_ready = 0; ALU inputs are held stable. At the end of the cycle:
    - reg[rd] <= alu_out; res_data <= alu_out; res_rd <= rd; res_zero <= alu_zf.
    - res_carry <= alu_carry if op == 00, else 0.
    - res_valid <= 1; go to IDLE.
- res_valid is high for exactly the one cycle following EXEC, then returns to 0.
- Latency and throughput:
  - Accept at edge N; write-back and result registers update at edge N+1; res_valid is high during cycle N+1..N+2.
  - Earliest next accept is edge N+2, so at most one ALU op per 2 cycles.
- Hazards: the read-after-write gap is guaranteed by the EXEC bubble; no forwarding is needed.
- Arithmetic:
  - The result is the ALU's DATA_W-bit output; mul is truncated to the low 8 bits.
  - shl ignores B; alu_b is still driven from rb.
- cmd_ra == cmd_rb == cmd_rd is legal. Operands are sampled before the write.
- Simultaneous events:
  - A load in IDLE may be accepted in the same cycle that res_valid is high.
  - The register write in that cycle is from the load only.
- Reset in EXEC aborts the operation: no write-back and no res_valid; all registers are cleared by reset anyway.
- cmd_* inputs are ignored when cmd_ready = 0.
- Debug read returns the current register contents, not yet including a write at the same edge.

Test Plan:
- Reset: hold rst_n low 2 cycles with cmd_valid = 1 -> cmd_ready = 0, res_valid = 0, alu_a = alu_b = 0, dbg_data = 0 for all four registers.
- Load r0 = 0xF0, r1 = 0x20, then add rd = r2, ra = r0, rb = r1 -> alu_a = 0xF0, alu_b = 0x20, alu_sel = 00 in EXEC; res_valid one cycle later with res_data = 0x10, res_carry = 1, res_zero = 0, res_rd = 2; dbg r2 = 0x10.
- mul r3 = r0 * r1 -> res_data = 0x00 (0x1E00 truncated), res_zero = 1, res_carry = 0 (even though the ALU carry input is 1).
- xor r1 = r1 ^ r1 -> res_data = 0x00, res_zero = 1, r1 cleared. shl r0 -> res_data = 0xE0, res_carry = 0.
- Back-to-back: cmd_valid held with add r2 = r2 + r2 twice starting from r2 = 0x10 -> cmd_ready low in each EXEC cycle; results 0x20 then 0x40; accepts 2 cycles apart.
- Reset mid-op: issue add r2 = r0 + r1, then drive rst_n low during EXEC -> no res_valid, all registers 0, cmd_ready 0 during reset and 1 in the cycle after release.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issue stage feeding a combinational ALU and writing results back to a small register file
module alu_op_sequencer #(
    parameter int DATA_W = 8,
    parameter int NREG   = 4,
    parameter int REG_AW = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_load,
    input  logic [1:0]        cmd_op,
    input  logic [REG_AW-1:0] cmd_ra,
    input  logic [REG_AW-1:0] cmd_rb,
    input  logic [REG_AW-1:0] cmd_rd,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_carry,
    input  logic              alu_zf,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic [REG_AW-1:0] res_rd,
    output logic              res_carry,
    output logic              res_zero,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    typedef enum logic {IDLE, EXEC} state_t;
    state_t state, state_nx;
    logic [DATA_W-1:0] regs [NREG];
    logic [REG_AW-1:0] rd_q;
    logic [1:0] op_q;
    logic accept;
    always_comb begin
        cmd_ready = rst_n && state == IDLE;
        accept = cmd_valid && cmd_ready;
        state_nx = state == EXEC ? IDLE : (accept && !cmd_load) ? EXEC : IDLE;
    end
    always_ff @(posedge clk)
        state <= !rst_n ? IDLE : state_nx;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            alu_a <= '0;
            alu_b <= '0;
            alu_sel <= '0;
            rd_q <= '0;
            op_q <= '0;
            res_valid <= 1'b0;
            res_data <= '0;
            res_rd <= '0;
            res_carry <= 1'b0;
            res_zero <= 1'b0;
        end else begin
            res_valid <= state == EXEC;
            if (state == EXEC) begin
                regs[rd_q] <= alu_out;
                res_data <= alu_out;
                res_rd <= rd_q;
                res_zero <= alu_zf;
                res_carry <= op_q == 2'b00 && alu_carry;
            end
            if (accept && cmd_load) regs[cmd_rd] <= cmd_imm;
            if (accept && !cmd_load) begin
                alu_a <= regs[cmd_ra];
                alu_b <= regs[cmd_rb];
                alu_sel <= cmd_op;
                rd_q <= cmd_rd;
                op_q <= cmd_op;
            end
        end
    end
    assign dbg_data = regs[dbg_addr];
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: randomized commands against a register-file reference model with a behavioural ALU
module tb_alu_op_sequencer;
    logic clk = 0, rst_n;
    logic cmd_valid, cmd_ready, cmd_load;
    logic [1:0] cmd_op, cmd_ra, cmd_rb, cmd_rd, res_rd, dbg_addr, alu_sel;
    logic [7:0] cmd_imm, alu_a, alu_b, alu_out, res_data, dbg_data;
    logic alu_carry, alu_zf, res_valid, res_carry, res_zero;
    logic [8:0] sum;
    int n_chk = 0, n_pass = 0;
    int mreg [4];

    alu_op_sequencer dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_load(cmd_load), .cmd_op(cmd_op), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
        .cmd_rd(cmd_rd), .cmd_imm(cmd_imm), .alu_a(alu_a), .alu_b(alu_b),
        .alu_sel(alu_sel), .alu_out(alu_out), .alu_carry(alu_carry), .alu_zf(alu_zf),
        .res_valid(res_valid), .res_data(res_data), .res_rd(res_rd),
        .res_carry(res_carry), .res_zero(res_zero), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    assign sum = {1'b0, alu_a} + {1'b0, alu_b};
    assign alu_carry = sum[8];
    assign alu_out = alu_sel == 2'd0 ? sum[7:0] : alu_sel == 2'd1 ? 8'(alu_a * alu_b) :
                     alu_sel == 2'd2 ? alu_a ^ alu_b : {alu_a[6:0], 1'b0};
    assign alu_zf = alu_out == 8'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_regs();
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1 chk("dbg_reg", dbg_data, mreg[i]);
        end
    endtask

    task automatic do_load(input logic [1:0] rd, input logic [7:0] imm);
        cmd_valid = 1; cmd_load = 1; cmd_rd = rd; cmd_imm = imm;
        cmd_ra = 2'($urandom); cmd_rb = 2'($urandom); cmd_op = 2'($urandom);
        #1 chk("load_ready", cmd_ready, 1);
        @(posedge clk); @(negedge clk);
        cmd_valid = 0;
        chk("load_no_strobe", res_valid, 0);
        mreg[rd] = imm;
        dbg_addr = rd;
        #1 chk("load_dbg", dbg_data, mreg[rd]);
    endtask

    task automatic do_op(input logic [1:0] op, input logic [1:0] ra, input logic [1:0] rb,
                         input logic [1:0] rd, input bit hold);
        int a, b, r;
        bit c;
        a = mreg[ra];
        b = mreg[rb];
        r = op == 0 ? (a + b) % 256 : op == 1 ? (a * b) % 256 : op == 2 ? a ^ b : (a * 2) % 256;
        c = op == 0 && a + b > 255;
        cmd_valid = 1; cmd_load = 0; cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_rd = rd;
        cmd_imm = 8'($urandom);
        #1 chk("op_ready", cmd_ready, 1);
        @(posedge clk); @(negedge clk);
        chk("exec_ready", cmd_ready, 0);
        chk("exec_a", alu_a, a);
        chk("exec_b", alu_b, b);
        chk("exec_sel", alu_sel, op);
        chk("exec_no_strobe", res_valid, 0);
        if (hold) begin
            cmd_load = 1; cmd_rd = 2'($urandom); cmd_imm = 8'($urandom);
        end else cmd_valid = 0;
        @(posedge clk); @(negedge clk);
        chk("res_valid", res_valid, 1);
        chk("res_data", res_data, r);
        chk("res_rd", res_rd, rd);
        chk("res_carry", res_carry, c);
        chk("res_zero", res_zero, r == 0);
        mreg[rd] = r;
        dbg_addr = rd;
        #1 chk("op_dbg", dbg_data, r);
    endtask

    initial begin
        rst_n = 0; cmd_valid = 1; cmd_load = 1; cmd_rd = 0; cmd_imm = 8'hFF;
        cmd_op = 0; cmd_ra = 0; cmd_rb = 0; dbg_addr = 0;
        foreach (mreg[i]) mreg[i] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_a", alu_a, 0);
        chk("rst_b", alu_b, 0);
        check_regs();
        @(negedge clk);
        rst_n = 1; cmd_valid = 0;
        do_load(0, 8'hF0);
        do_load(1, 8'h20);
        do_op(0, 0, 1, 2, 0);
        chk("add_const", res_data, 8'h10);
        chk("add_carry_const", res_carry, 1);
        do_op(1, 0, 1, 3, 0);
        chk("mul_const", res_data, 8'h00);
        chk("mul_carry_const", res_carry, 0);
        do_op(2, 1, 1, 1, 0);
        do_op(3, 0, 1, 0, 0);
        chk("shl_const", res_data, 8'hE0);
        do_load(0, 8'hF0);
        do_load(1, 8'h20);
        do_op(0, 2, 2, 2, 1);
        do_op(0, 2, 2, 2, 0);
        chk("b2b_const", res_data, 8'h40);
        do_load(3, 8'h5A);
        @(negedge clk);
        chk("strobe_drop", res_valid, 0);
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) == 0) do_load(2'($urandom), 8'($urandom));
            else do_op(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
                       i < 59 && $urandom_range(0, 1) == 1);
        end
        @(negedge clk);
        cmd_valid = 1; cmd_load = 0; cmd_op = 0; cmd_ra = 0; cmd_rb = 1; cmd_rd = 2;
        @(posedge clk); @(negedge clk);
        chk("abort_exec", cmd_ready, 0);
        rst_n = 0; cmd_valid = 0;
        foreach (mreg[i]) mreg[i] = 0;
        @(posedge clk); @(negedge clk);
        chk("abort_valid", res_valid, 0);
        chk("abort_ready", cmd_ready, 0);
        chk("abort_a", alu_a, 0);
        check_regs();
        @(posedge clk); @(negedge clk);
        chk("abort_valid2", res_valid, 0);
        rst_n = 1;
        #1 chk("release_ready", cmd_ready, 1);
        @(negedge clk);
        chk("release_idle_valid", res_valid, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
